uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receive path inside the uart block. Supported frame formats:
- configurable data width
- optional even/odd parity
- 1 or 2 stop bits

It adds 3-sample majority voting, framing and parity error detection, and a valid/ready output handshake with overrun detection. It sits between the board RX pin and any byte consumer (LED latch, command decoder, FIFO).

Parameters:
CLKS_PER_BIT, 8, clk cycles per UART bit; legal range >=4
DATA_BITS, 8, data bits per frame, sent LSB first; legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits checked; 1 or 2

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
rx  input  1  raw serial line, idle high, asynchronous to clk
data  output  DATA_BITS  received word; held stable while valid=1
valid  output  1  data holds an unconsumed word
ready  input  1  consumer accepts data when valid&&ready on a clk edge
parity_err  output  1  one-cycle pulse: frame dropped, parity mismatch
frame_err  output  1  one-cycle pulse: frame dropped, stop bit sampled low
overrun  output  1  one-cycle pulse: good frame dropped because valid was still high
busy  output  1  high whenever the state machine is not in IDLE

Behaviour:
- Reset: async on rst high.
  - All outputs reset to 0, except data, which resets to all-zero.
  - The synchroniser flops reset to 1 (idle line).
  - The state machine goes to IDLE.
  - A reset mid-frame abandons the frame; no pulse is emitted.
- Input conditioning: rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s, so there is 2 cycles of latency.
- Bit timer: counts 0..CLKS_PER_BIT-1. Mid-point M = CLKS_PER_BIT/2 (integer divide).
  - Samples are taken at counts M-1, M and M+1.
  - Bit value = majority of the 3 samples.
- States:
  - IDLE: on rx_s==0, go to START with the timer cleared.
  - START: at count M+1, if the majority is 1 this is a false start, so go to IDLE. Otherwise, at count CLKS_PER_BIT-1 go to DATA.
  - DATA: shift DATA_BITS bits into the shift register, LSB first. After the last bit, go to PARITY if PARITY!=0, else go to STOP.
  - PARITY: sample 1 bit. Even parity: the XOR of data and parity bit must be 0. Odd parity: it must be 1. Record a mismatch flag.
  - STOP: sample STOP_BITS bits. The decision is made at count M+1 of the final stop bit.
  - WAIT_IDLE: entered after a frame error. Stay until rx_s==1, then go to IDLE. This absorbs breaks.
- Decision at the final stop sample, evaluated in this order:
  1. Any stop bit low: pulse frame_err, go to WAIT_IDLE. The parity check is ignored.
  2. Parity mismatch: pulse parity_err, go to IDLE.
  3. valid==1 and ready==0 on this cycle: pulse overrun, keep the old data, go to IDLE.
  4. Otherwise: load data and set valid on the next edge, then go to IDLE. The receiver may detect the next start bit on the following cycle.
- Handshake:
  - valid clears on the edge where valid&&ready, unless a new word loads on the same edge. In that case data updates and valid stays 1, with no overrun.
  - data must not change while valid=1 except on that consume-and-load edge.
- Latency: valid rises 1 clk after the final stop-bit decision. That is about 2 + (1 + DATA_BITS + parity + STOP_BITS - 0.5) × CLKS_PER_BIT cycles after the rx falling edge.
- Only one error pulse fires per frame, and error pulses never coincide with valid rising.

Test Plan:
1. Defaults (8N1, CLKS_PER_BIT=8), ready=1. Drive rx low for 8 cycles, then bits 1,0,0,0,0,1,1,0, then stop high, each held 8 cycles. -> data=0x61, valid high for exactly 1 cycle, no error pulse, busy low afterwards.
2. PARITY=1 (even). Send 0x61 with parity bit 1, then send 0x61 with parity bit 0. -> First frame: data=0x61, valid. Second frame: parity_err pulses once, valid stays 0, data stays 0x61.
3. Defaults. Send 0x55 with the stop bit driven low and rx then held low for 40 cycles, then release, then send 0xA5. -> frame_err pulses exactly once, busy stays high until rx returns high, then data=0xA5 and valid.
4. Defaults, ready=0. Send 0x12, then 0x34. -> valid=1 with data=0x12, overrun pulses at the end of the second frame, data stays 0x12. Raise ready for 1 cycle -> valid clears.
5. Defaults. Glitch rx low for 2 cycles only (less than the M+1 sample point). -> Back to IDLE, no valid, no pulses. Also pulse rst mid-frame at data bit 3 -> no outputs fire, and the next clean 0x61 frame is received correctly.
6. DATA_BITS=7, STOP_BITS=2, PARITY=2 (odd). Send 0x7F, parity 0, two stop bits; then repeat with the second stop bit low. -> First frame: data=0x7F and valid. Second frame: frame_err pulses.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// parity/framing checks and a valid/ready output with overrun detection.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int MID = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] SMP0 = CW'(MID - 1);
    localparam logic [CW-1:0] SMP1 = CW'(MID);
    localparam logic [CW-1:0] SMP2 = CW'(MID + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             smp_q, smp_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bad_q, par_bad_d;
    logic                   stop_bad_q, stop_bad_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                   maj, at_mid, bit_end;

    // Majority of the two stored samples and the live third sample.
    assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    assign at_mid  = (cnt_q == SMP2);
    assign bit_end = (cnt_q == LAST);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = bit_end ? '0 : cnt_q + CW'(1);
        smp_d      = smp_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;

        if (cnt_q == SMP0) smp_d[0] = rx_s_q;
        if (cnt_q == SMP1) smp_d[1] = rx_s_q;
        if (valid_q && ready) valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                idx_d      = '0;
                par_bad_d  = 1'b0;
                stop_bad_d = 1'b0;
                if (!rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                if (at_mid && maj)  state_d = ST_IDLE;
                else if (bit_end)   state_d = ST_DATA;
            end
            ST_DATA: begin
                if (at_mid) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (idx_q == 4'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                // Odd parity flips the sense of the XOR check.
                if (at_mid)  par_bad_d = (^shift_q) ^ maj ^ (PARITY == 2);
                if (bit_end) state_d   = ST_STOP;
            end
            ST_STOP: begin
                if (at_mid && idx_q == 4'(STOP_BITS - 1)) begin
                    if (stop_bad_q || !maj) begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end else if (par_bad_q) begin
                        perr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (valid_q && !ready) begin
                        ovr_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (at_mid) begin
                    stop_bad_d = stop_bad_q | ~maj;
                end
                if (bit_end) idx_d = idx_q + 4'd1;
            end
            ST_WAIT_IDLE: begin
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            smp_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            // NOTE: data is a plain register, not a memory, so it is reset with everything else.
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            smp_q      <= smp_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7O2) driven from
// a vector table, hand-written corner sequences and randomized frames.
module tb_uart_rx_param;

    localparam int CKB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx_v;
    logic [2:0] ready_v;
    wire  [7:0] data_a, data_b;
    wire  [6:0] data_c;
    wire  [2:0] valid_v, perr_v, ferr_v, ovr_v, busy_v;

    always #5 clk = ~clk;

    uart_rx_param u_8n1 (
        .clk(clk), .rst(rst), .rx(rx_v[0]), .data(data_a), .valid(valid_v[0]), .ready(ready_v[0]),
        .parity_err(perr_v[0]), .frame_err(ferr_v[0]), .overrun(ovr_v[0]), .busy(busy_v[0])
    );
    uart_rx_param #(.PARITY(1)) u_8e1 (
        .clk(clk), .rst(rst), .rx(rx_v[1]), .data(data_b), .valid(valid_v[1]), .ready(ready_v[1]),
        .parity_err(perr_v[1]), .frame_err(ferr_v[1]), .overrun(ovr_v[1]), .busy(busy_v[1])
    );
    uart_rx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst(rst), .rx(rx_v[2]), .data(data_c), .valid(valid_v[2]), .ready(ready_v[2]),
        .parity_err(perr_v[2]), .frame_err(ferr_v[2]), .overrun(ovr_v[2]), .busy(busy_v[2])
    );

    // Frame format of each instance, as the reference model sees it.
    int dbits [3] = '{8, 8, 7};
    int pmode [3] = '{0, 1, 2};
    int sbits [3] = '{1, 1, 2};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] data_of(input int u);
        case (u)
            0:       return {1'b0, data_a};
            1:       return {1'b0, data_b};
            default: return {2'b00, data_c};
        endcase
    endfunction

    // Event monitor: valid rises, valid-high cycles, pulse-high cycles.
    int         vrise [3] = '{0, 0, 0};
    int         vhigh [3] = '{0, 0, 0};
    int         pe    [3] = '{0, 0, 0};
    int         fe    [3] = '{0, 0, 0};
    int         ov    [3] = '{0, 0, 0};
    logic [2:0] valid_prev = 3'b000;

    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (valid_v[u] && !valid_prev[u]) vrise[u]++;
            if (valid_v[u]) vhigh[u]++;
            if (perr_v[u])  pe[u]++;
            if (ferr_v[u])  fe[u]++;
            if (ovr_v[u])   ov[u]++;
            if (perr_v[u] || ferr_v[u] || ovr_v[u])
                check("pulse_with_valid_rise", 32'(valid_v[u] && !valid_prev[u]), 32'd0);
        end
        valid_prev = valid_v;
    end

    task automatic drive_bit(input int u, input logic b);
        rx_v[u] = b;
        repeat (CKB) @(negedge clk);
    endtask

    // Builds the frame from the format rules: start, data LSB first,
    // parity (optionally inverted), stop bits (slow marks low stop bits).
    task automatic send_frame(input int u, input logic [8:0] word, input logic pflip,
                              input logic [1:0] slow, input int hold_low);
        int   ones;
        logic pbit;
        ones = 0;
        drive_bit(u, 1'b0);
        for (int i = 0; i < dbits[u]; i++) begin
            drive_bit(u, word[i]);
            if (word[i]) ones++;
        end
        if (pmode[u] != 0) begin
            pbit = (pmode[u] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            drive_bit(u, pbit ^ pflip);
        end
        for (int s = 0; s < sbits[u]; s++) drive_bit(u, ~slow[s]);
        if (hold_low > 0) begin
            rx_v[u] = 1'b0;
            repeat (hold_low) @(negedge clk);
        end else begin
            rx_v[u] = 1'b1;
        end
    endtask

    task automatic run_frame(input string tag, input int u, input logic [8:0] word,
                             input logic pflip, input logic [1:0] slow, input logic exp_ok,
                             input logic exp_perr, input logic exp_ferr, input logic [8:0] exp_data);
        int r0, h0, p0, f0, o0;
        r0 = vrise[u]; h0 = vhigh[u]; p0 = pe[u]; f0 = fe[u]; o0 = ov[u];
        send_frame(u, word, pflip, slow, 0);
        repeat (3 * CKB) @(negedge clk);
        check({tag, "_valid_rise"}, 32'(vrise[u] - r0), 32'(exp_ok));
        check({tag, "_valid_cycles"}, 32'(vhigh[u] - h0), 32'(exp_ok));
        check({tag, "_parity_err"}, 32'(pe[u] - p0), 32'(exp_perr));
        check({tag, "_frame_err"}, 32'(fe[u] - f0), 32'(exp_ferr));
        check({tag, "_overrun"}, 32'(ov[u] - o0), 32'd0);
        check({tag, "_data"}, 32'(data_of(u)), 32'(exp_data));
        check({tag, "_busy"}, 32'(busy_v[u]), 32'd0);
    endtask

    typedef struct {
        int         u;
        logic [8:0] word;
        logic       pflip;
        logic [1:0] slow;
        logic       exp_ok;
        logic       exp_perr;
        logic       exp_ferr;
        logic [8:0] exp_data;
    } vec_t;

    vec_t       tbl [11];
    logic [8:0] model_data [3];

    initial begin
        int r0, p0, f0, o0, u;
        logic [8:0] w;
        logic       pf, ok;
        logic [1:0] sl;

        tbl[0]  = '{0, 9'h061, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 9'h061};
        tbl[1]  = '{1, 9'h061, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 9'h061};
        tbl[2]  = '{1, 9'h061, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 9'h061};
        tbl[3]  = '{0, 9'h055, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 9'h061};
        tbl[4]  = '{0, 9'h0A5, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 9'h0A5};
        tbl[5]  = '{2, 9'h07F, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 9'h07F};
        tbl[6]  = '{2, 9'h07F, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 9'h07F};
        tbl[7]  = '{2, 9'h02A, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 9'h07F};
        tbl[8]  = '{1, 9'h000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 9'h000};
        tbl[9]  = '{2, 9'h015, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 9'h07F};
        tbl[10] = '{0, 9'h03C, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 9'h03C};

        rst = 1'b1; rx_v = 3'b111; ready_v = 3'b111;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_data", 32'(data_of(i)), 32'd0);
            check("reset_flags", {27'd0, valid_v[i], perr_v[i], ferr_v[i], ovr_v[i], busy_v[i]}, 32'd0);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        model_data = '{9'h000, 9'h000, 9'h000};

        // Table-driven frames across all three formats.
        for (int i = 0; i < 11; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].u, tbl[i].word, tbl[i].pflip, tbl[i].slow,
                      tbl[i].exp_ok, tbl[i].exp_perr, tbl[i].exp_ferr, tbl[i].exp_data);
            if (tbl[i].exp_ok) model_data[tbl[i].u] = tbl[i].word;
        end

        // Break: stop bit low, line stays low 40 more cycles, then a clean frame.
        f0 = fe[0]; r0 = vrise[0];
        send_frame(0, 9'h055, 1'b0, 2'b01, 40);
        check("break_busy_while_low", 32'(busy_v[0]), 32'd1);
        check("break_frame_err_low", 32'(fe[0] - f0), 32'd1);
        rx_v[0] = 1'b1;
        repeat (3 * CKB) @(negedge clk);
        check("break_frame_err_once", 32'(fe[0] - f0), 32'd1);
        check("break_busy_released", 32'(busy_v[0]), 32'd0);
        check("break_no_valid", 32'(vrise[0] - r0), 32'd0);
        run_frame("after_break", 0, 9'h0A5, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 9'h0A5);
        model_data[0] = 9'h0A5;

        // Overrun: consumer stalled across two frames.
        ready_v[0] = 1'b0;
        r0 = vrise[0]; o0 = ov[0];
        send_frame(0, 9'h012, 1'b0, 2'b00, 0);
        repeat (3 * CKB) @(negedge clk);
        check("ovr_first_valid", 32'(valid_v[0]), 32'd1);
        check("ovr_first_data", 32'(data_of(0)), 32'h12);
        send_frame(0, 9'h034, 1'b0, 2'b00, 0);
        repeat (3 * CKB) @(negedge clk);
        check("ovr_pulse", 32'(ov[0] - o0), 32'd1);
        check("ovr_valid_held", 32'(valid_v[0]), 32'd1);
        check("ovr_data_held", 32'(data_of(0)), 32'h12);
        check("ovr_single_rise", 32'(vrise[0] - r0), 32'd1);
        ready_v[0] = 1'b1;
        @(negedge clk);
        ready_v[0] = 1'b0;
        @(negedge clk);
        check("ovr_consumed", 32'(valid_v[0]), 32'd0);
        ready_v[0] = 1'b1;
        model_data[0] = 9'h012;

        // Randomized frames against the format model.
        for (int n = 0; n < 24; n++) begin
            u  = $urandom_range(0, 2);
            w  = 9'($urandom) & 9'((1 << dbits[u]) - 1);
            pf = ($urandom_range(0, 3) == 0);
            sl = 2'b00;
            if ($urandom_range(0, 3) == 0) sl = (sbits[u] == 2) ? 2'($urandom_range(1, 3)) : 2'b01;
            ok = (sl == 2'b00) && !(pmode[u] != 0 && pf);
            if (ok) model_data[u] = w;
            run_frame($sformatf("rnd%0d", n), u, w, pf, sl, ok,
                      (sl == 2'b00) && pmode[u] != 0 && pf, sl != 2'b00, model_data[u]);
        end

        // Glitch shorter than the sample window is a false start.
        r0 = vrise[0]; p0 = pe[0]; f0 = fe[0];
        rx_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rx_v[0] = 1'b1;
        repeat (3 * CKB) @(negedge clk);
        check("glitch_no_valid", 32'(vrise[0] - r0), 32'd0);
        check("glitch_no_pulse", 32'((pe[0] - p0) + (fe[0] - f0)), 32'd0);
        check("glitch_busy", 32'(busy_v[0]), 32'd0);

        // Reset in the middle of data bit 3 abandons the frame silently.
        r0 = vrise[0]; p0 = pe[0]; f0 = fe[0]; o0 = ov[0];
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        rx_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; rx_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CKB) @(negedge clk);
        check("rst_mid_no_events", 32'((vrise[0] - r0) + (pe[0] - p0) + (fe[0] - f0) + (ov[0] - o0)), 32'd0);
        check("rst_mid_data", 32'(data_of(0)), 32'd0);
        check("rst_mid_busy", 32'(busy_v[0]), 32'd0);
        run_frame("after_rst", 0, 9'h061, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 9'h061);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
